// File: rtl/sram_bubble_sort.sv
// In-place bubble-sort engine driving a synchronous single-port SRAM.
// Reads each adjacent pair, compares, and writes it back swapped when out of order.
module sram_bubble_sort #(
    parameter int unsigned DEPTH   = 12,
    parameter int unsigned DW      = 8,
    parameter int unsigned AW      = 8,
    parameter int unsigned DESCEND = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_dir,
    output logic [DW-1:0] mem_dato_e,
    input  logic [DW-1:0] mem_dato_s,
    output logic [7:0]    pass_cnt,
    output logic [7:0]    swap_cnt
);

    typedef enum logic [2:0] {
        IDLE, RD_A, RD_B, CAP_B, CMP, WR_A, WR_B, DONE
    } state_t;

    localparam logic [AW-1:0] LIMIT0 = AW'(DEPTH - 1);

    state_t        state, state_nx;
    logic [AW-1:0] i, limit, i_nx1;
    logic [DW-1:0] a, b;
    logic          swapped;
    logic          do_swap, advance, pass_end, finish;
    logic          start_sort, step_i, new_pass;

    assign i_nx1    = i + AW'(1);
    assign do_swap  = (DESCEND != 0) ? (a < b) : (a > b);
    assign pass_end = !(i_nx1 < limit);
    // WR_B sets swapped on the same edge it advances, so fold that in here.
    assign finish   = !(swapped || (state == WR_B)) || (limit == AW'(1));

    always_comb begin
        state_nx   = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_dir    = '0;
        mem_dato_e = '0;
        done       = 1'b0;
        advance    = 1'b0;
        start_sort = 1'b0;
        step_i     = 1'b0;
        new_pass   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_sort = 1'b1;
                    state_nx   = RD_A;
                end
            end
            RD_A: begin
                mem_en   = 1'b1;
                mem_dir  = i;
                state_nx = RD_B;
            end
            RD_B: begin
                mem_en   = 1'b1;
                mem_dir  = i_nx1;
                state_nx = CAP_B;
            end
            CAP_B: state_nx = CMP;
            CMP: begin
                if (do_swap) state_nx = WR_A;
                else         advance  = 1'b1;
            end
            WR_A: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_dir    = i;
                mem_dato_e = b;
                state_nx   = WR_B;
            end
            WR_B: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_dir    = i_nx1;
                mem_dato_e = a;
                advance    = 1'b1;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (advance) begin
            if (!pass_end) begin
                step_i   = 1'b1;
                state_nx = RD_A;
            end else if (finish) begin
                state_nx = DONE;
            end else begin
                new_pass = 1'b1;
                state_nx = RD_A;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            i        <= '0;
            limit    <= LIMIT0;
            swapped  <= 1'b0;
            pass_cnt <= '0;
            swap_cnt <= '0;
            a        <= '0;
            b        <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE) && (state_nx != DONE);
            if (start_sort) begin
                i        <= '0;
                limit    <= LIMIT0;
                swapped  <= 1'b0;
                pass_cnt <= 8'd1;
                swap_cnt <= '0;
            end
            if (state == RD_B)  a <= mem_dato_s;
            if (state == CAP_B) b <= mem_dato_s;
            if (state == WR_B) begin
                swapped <= 1'b1;
                if (swap_cnt != 8'hFF) swap_cnt <= swap_cnt + 8'd1;
            end
            if (step_i) i <= i_nx1;
            if (new_pass) begin
                limit    <= limit - AW'(1);
                i        <= '0;
                swapped  <= 1'b0;
                pass_cnt <= pass_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sram_bubble_sort.sv
// Directed bench for sram_bubble_sort: two engines (ascending, descending) each
// attached to a 12x8 registered-read SRAM model.
module tb_sram_bubble_sort;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       busy0, busy1, done0, done1;
    logic       en0, en1, we0, we1;
    logic [7:0] dir0, dir1, de0, de1, ds0, ds1;
    logic [7:0] pc0, pc1, sc0, sc1;

    logic [7:0] ram0 [12];
    logic [7:0] ram1 [12];
    logic [7:0] init0 [12];
    logic [7:0] init1 [12];
    logic       load0 = 1'b0, load1 = 1'b0;
    int         viol = 0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sram_bubble_sort #(.DEPTH(12), .DW(8), .AW(8), .DESCEND(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .mem_en(en0), .mem_we(we0), .mem_dir(dir0), .mem_dato_e(de0),
        .mem_dato_s(ds0), .pass_cnt(pc0), .swap_cnt(sc0)
    );

    sram_bubble_sort #(.DEPTH(12), .DW(8), .AW(8), .DESCEND(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .mem_en(en1), .mem_we(we1), .mem_dir(dir1), .mem_dato_e(de1),
        .mem_dato_s(ds1), .pass_cnt(pc1), .swap_cnt(sc1)
    );

    always @(posedge clk) begin
        if (load0) ram0 <= init0;
        else if (en0) begin
            if (we0) ram0[dir0[3:0]] <= de0;
            else     ds0 <= ram0[dir0[3:0]];
        end
        if (load1) ram1 <= init1;
        else if (en1) begin
            if (we1) ram1[dir1[3:0]] <= de1;
            else     ds1 <= ram1[dir1[3:0]];
        end
    end

    // A write strobe without enable would never reach the SRAM.
    always @(negedge clk) begin
        if ((we0 && !en0) || (we1 && !en1)) viol = viol + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic load(input int sel, input logic [7:0] v [12]);
        @(negedge clk);
        if (sel == 0) begin init0 = v; load0 = 1'b1; end
        else          begin init1 = v; load1 = 1'b1; end
        @(negedge clk);
        load0 = 1'b0;
        load1 = 1'b0;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else          start1 = v;
    endtask

    // Pulses start, then samples every negedge until done has been seen plus a few idle cycles.
    task automatic run_sort(input int sel, input int restart_at,
                            output int busy_cyc, output int done_cnt, output int done_idx);
        logic b, d;
        busy_cyc = 0;
        done_cnt = 0;
        done_idx = -1;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        for (int k = 1; k <= 3000; k++) begin
            set_start(sel, k == restart_at);
            b = (sel == 0) ? busy0 : busy1;
            d = (sel == 0) ? done0 : done1;
            if (b) busy_cyc++;
            if (d) begin
                done_cnt++;
                if (done_idx < 0) done_idx = k;
            end
            if (done_idx >= 0 && k >= done_idx + 3) break;
            @(negedge clk);
        end
        set_start(sel, 1'b0);
        check($sformatf("dut%0d done seen within budget", sel), int'(done_idx >= 0), 1);
    endtask

    task automatic check_ram(input string tag, input int sel, input logic [7:0] exp [12]);
        for (int unsigned k = 0; k < 12; k++)
            check($sformatf("%s ram[%0d]", tag, k), (sel == 0) ? ram0[k] : ram1[k], exp[k]);
    endtask

    logic [7:0] t1_data [12];
    logic [7:0] t1_asc  [12];
    logic [7:0] t1_desc [12];
    logic [7:0] rev12   [12];
    logic [7:0] one12   [12];
    int bc, dc, di;

    initial begin
        t1_data = '{8'd90, 8'd80, 8'd40, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd100, 8'd101, 8'd102};
        t1_asc  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd40, 8'd50, 8'd60, 8'd80, 8'd90, 8'd100, 8'd101, 8'd102};
        t1_desc = '{8'd102, 8'd101, 8'd100, 8'd90, 8'd80, 8'd60, 8'd50, 8'd40, 8'd40, 8'd30, 8'd20, 8'd10};
        rev12   = '{8'd12, 8'd11, 8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        one12   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};

        repeat (3) @(negedge clk);
        check("reset busy", busy0, 0);
        check("reset done", done0, 0);
        check("reset mem_en", en0, 0);
        check("reset mem_we", we0, 0);
        check("reset mem_dir", dir0, 0);
        check("reset mem_dato_e", de0, 0);
        check("reset pass_cnt", pc0, 0);
        check("reset swap_cnt", sc0, 0);
        rst = 1'b0;

        // T1: 9 passes (11+10+..+3 = 63 compares), 33 swaps -> 63*4 + 33*2 = 318 busy cycles
        load(0, t1_data);
        run_sort(0, 0, bc, dc, di);
        check_ram("T1", 0, t1_asc);
        check("T1 swap_cnt", sc0, 33);
        check("T1 pass_cnt", pc0, 9);
        check("T1 busy cycles", bc, 318);
        check("T1 done pulses", dc, 1);
        check("T1 done cycle", di, 319);

        // T2: already sorted -> one pass of 11 compares, 44 busy cycles
        run_sort(0, 0, bc, dc, di);
        check("T2 swap_cnt", sc0, 0);
        check("T2 pass_cnt", pc0, 1);
        check("T2 busy cycles", bc, 44);
        check("T2 done cycle", di, 45);
        check("T2 done pulses", dc, 1);
        check("T2 counters hold after done", pc0 * 256 + sc0, 256);

        // T3: reversed -> 66 swaps, 11 passes, 66*6 busy cycles
        load(0, rev12);
        run_sort(0, 0, bc, dc, di);
        check_ram("T3", 0, one12);
        check("T3 swap_cnt", sc0, 66);
        check("T3 pass_cnt", pc0, 11);
        check("T3 busy cycles", bc, 396);

        // T4: descending -> 32 swaps (66 pairs - 33 inversions - 1 equal pair), 11 passes
        load(1, t1_data);
        run_sort(1, 0, bc, dc, di);
        check_ram("T4", 1, t1_desc);
        check("T4 swap_cnt", sc1, 32);
        check("T4 pass_cnt", pc1, 11);
        check("T4 busy cycles", bc, 328);
        check("T4 write without enable", viol, 0);

        // T5: second start while busy is ignored
        load(0, t1_data);
        run_sort(0, 10, bc, dc, di);
        check_ram("T5", 0, t1_asc);
        check("T5 swap_cnt", sc0, 33);
        check("T5 pass_cnt", pc0, 9);
        check("T5 busy cycles", bc, 318);
        check("T5 done pulses", dc, 1);

        // T6: async reset 30 cycles in (during a read of compare 5, after its previous write landed)
        load(0, t1_data);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("T6 mem_en before reset", en0, 1);
        rst = 1'b1;
        #1;
        check("T6 async busy", busy0, 0);
        check("T6 async mem_en", en0, 0);
        check("T6 async pass_cnt", pc0, 0);
        check("T6 async swap_cnt", sc0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_sort(0, 0, bc, dc, di);
        check_ram("T6", 0, t1_asc);
        check("T6 done pulses", dc, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
